// File: rtl/wave_capture_multi.sv
// Waveform capture for the scope display path.
// Watches the codec sample stream and arms on a trigger: a rising or falling level crossing, or
// free-run. It then writes one frame of decimated, display-scaled samples into the half of a
// ping-pong RAM that the display is not reading. When the frame is complete it flips read_index,
// but only once the display reports idle.
//
// Ports
//   clk               system clock
//   reset             synchronous, active-high reset
//   new_sample_ready  one-cycle strobe qualifying new_sample_in
//   new_sample_in     signed sample
//   trig_mode         00 rising, 01 falling, 10 free-run, 11 rising
//   trig_level        signed trigger threshold
//   decim             keep 1 of every (decim+1) samples, latched at trigger
//   wave_display_idle display is not reading the RAM; flip allowed
//   write_address     {~read_index, frame index}
//   write_enable      RAM write strobe, one cycle per stored sample
//   write_sample      display-scaled sample
//   read_index        RAM half the display reads
//   capture_active    a frame is being captured
//   frame_done        one-cycle pulse coincident with the read_index toggle
module wave_capture_multi #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned DECIM_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic [1:0]              trig_mode,
  input  logic [SAMPLE_WIDTH-1:0] trig_level,
  input  logic [DECIM_WIDTH-1:0]  decim,
  input  logic                    wave_display_idle,
  output logic [ADDR_WIDTH:0]     write_address,
  output logic                    write_enable,
  output logic [OUT_WIDTH-1:0]    write_sample,
  output logic                    read_index,
  output logic                    capture_active,
  output logic                    frame_done
);

  typedef enum logic [1:0] {StArmed, StCapture, StWaitFlip} state_e;

  // Full-scale positive display code; subtracting from it inverts the axis so that positive
  // samples plot upward.
  localparam logic [OUT_WIDTH-1:0] MidCode = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  state_e                         state_q, state_d;
  logic signed [SAMPLE_WIDTH-1:0] curr_q;
  logic [1:0]                     hist_cnt_q;
  logic [DECIM_WIDTH-1:0]         decim_lat_q, decim_lat_d;
  logic [DECIM_WIDTH-1:0]         decim_cnt_q, decim_cnt_d;
  logic [ADDR_WIDTH-1:0]          index_q;

  logic                           history_valid;
  logic                           rise_hit, fall_hit, trig_hit;
  logic                           store, flip;
  logic [OUT_WIDTH-1:0]           sample_top, sample_scaled;

  // curr_q is the previous sample relative to the incoming strobe. With at least one earlier
  // strobe, this strobe completes the two-sample history needed for a crossing test.
  assign history_valid = (hist_cnt_q != 2'd0);

  assign rise_hit = (curr_q < $signed(trig_level)) &&
                    ($signed(new_sample_in) >= $signed(trig_level));
  assign fall_hit = (curr_q >= $signed(trig_level)) &&
                    ($signed(new_sample_in) < $signed(trig_level));

  assign sample_top    = new_sample_in[SAMPLE_WIDTH-1 -: OUT_WIDTH];
  assign sample_scaled = MidCode - sample_top;

  assign flip = (state_q == StWaitFlip) && wave_display_idle;

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      2'b01:   trig_hit = history_valid && fall_hit;
      2'b10:   trig_hit = 1'b1;
      default: trig_hit = history_valid && rise_hit;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    store       = 1'b0;
    decim_lat_d = decim_lat_q;
    decim_cnt_d = decim_cnt_q;
    unique case (state_q)
      StArmed: begin
        if (new_sample_ready && trig_hit) begin
          // The triggering sample itself is stored at index 0.
          state_d     = StCapture;
          store       = 1'b1;
          decim_lat_d = decim;
          decim_cnt_d = decim;
        end
      end
      StCapture: begin
        if (new_sample_ready) begin
          if (decim_cnt_q == '0) begin
            store       = 1'b1;
            decim_cnt_d = decim_lat_q;
            if (&index_q) begin
              state_d = StWaitFlip;
            end
          end else begin
            decim_cnt_d = decim_cnt_q - 1'b1;
          end
        end
      end
      StWaitFlip: begin
        if (wave_display_idle) begin
          state_d = StArmed;
        end
      end
      default: state_d = StArmed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StArmed;
      curr_q         <= '0;
      hist_cnt_q     <= 2'd0;
      decim_lat_q    <= '0;
      decim_cnt_q    <= '0;
      index_q        <= '0;
      write_address  <= '0;
      write_enable   <= 1'b0;
      write_sample   <= '0;
      read_index     <= 1'b0;
      capture_active <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state_q     <= state_d;
      decim_lat_q <= decim_lat_d;
      decim_cnt_q <= decim_cnt_d;
      if (new_sample_ready) begin
        curr_q <= $signed(new_sample_in);
        if (hist_cnt_q != 2'd2) begin
          hist_cnt_q <= hist_cnt_q + 2'd1;
        end
      end
      write_enable <= store;
      if (store) begin
        write_address <= {~read_index, index_q};
        write_sample  <= sample_scaled;
        index_q       <= index_q + 1'b1;
      end
      // Kept high through the cycle that carries the final write.
      capture_active <= (state_d == StCapture) || store;
      read_index     <= read_index ^ flip;
      frame_done     <= flip;
    end
  end

endmodule

// File: tb/tb_wave_capture_multi.sv
// Self-checking bench for wave_capture_multi: directed stimulus pushes expected RAM writes and
// flips into queues; a monitor pops and compares whenever the DUT presents one.
module tb_wave_capture_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic [1:0]  trig_mode;
  logic [15:0] trig_level;
  logic [3:0]  decim;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  logic        capture_active;
  logic        frame_done;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic ri;
    logic adj;  // flip expected on the cycle right after the last write
  } flip_t;

  wr_t   wq[$];
  flip_t fq[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  wave_capture_multi dut (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .trig_mode        (trig_mode),
    .trig_level       (trig_level),
    .decim            (decim),
    .wave_display_idle(wave_display_idle),
    .write_address    (write_address),
    .write_enable     (write_enable),
    .write_sample     (write_sample),
    .read_index       (read_index),
    .capture_active   (capture_active),
    .frame_done       (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic half, input int idx, input int top);
    logic [7:0] i8;
    logic [7:0] t8;
    wr_t        w;
    i8     = idx[7:0];
    t8     = top[7:0];
    w.addr = {half, i8};
    w.data = 8'd127 - t8;
    wq.push_back(w);
  endtask

  task automatic push_flip(input logic ri, input logic adj);
    flip_t f;
    f.ri  = ri;
    f.adj = adj;
    fq.push_back(f);
  endtask

  task automatic strobe(input int v);
    @(negedge clk);
    new_sample_ready = 1'b1;
    new_sample_in    = v[15:0];
    @(negedge clk);
    new_sample_ready = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic       prev_we = 1'b0;
  logic [8:0] prev_addr = '0;
  always @(posedge clk) begin
    #1;
    if (write_enable) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", write_address,
                 write_sample);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (write_address !== e.addr || write_sample !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   write_address, write_sample, e.addr, e.data);
        end
      end
    end
    if (frame_done) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame_done: read_index=%0b, none expected", read_index);
      end else begin
        flip_t f;
        f = fq.pop_front();
        if (read_index !== f.ri || (f.adj && !(prev_we && prev_addr[7:0] == 8'hFF))) begin
          errors++;
          $display("FAIL frame_done: got read_index=%0b prev_we=%0b prev_addr=%0h expected %0b",
                   read_index, prev_we, prev_addr, f.ri);
        end
      end
    end
    prev_we   = write_enable;
    prev_addr = write_address;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    reset             = 1'b1;
    new_sample_ready  = 1'b0;
    new_sample_in     = '0;
    trig_mode         = 2'b00;
    trig_level        = 16'd0;
    decim             = 4'd0;
    wave_display_idle = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_we", write_enable, 0);
    check("reset_addr", write_address, 0);
    check("reset_sample", write_sample, 0);
    check("reset_read_index", read_index, 0);
    check("reset_capture_active", capture_active, 0);
    check("reset_frame_done", frame_done, 0);

    // Frame 1: rising zero crossing, decim 0, idle held high.
    push_flip(1'b1, 1'b1);
    strobe(-100);
    push_wr(1'b1, 0, 0);
    strobe(50);
    check("capture_active_after_trigger", capture_active, 1);
    for (int k = 1; k < 256; k++) begin
      push_wr(1'b1, k, k);
      strobe(k << 8);
    end
    check("capture_active_last_write", capture_active, 1);
    repeat (4) @(negedge clk);
    check("frame1_read_index", read_index, 1);
    check("frame1_capture_idle", capture_active, 0);

    // Frame 2: falling through 1000, writes to half 0, display busy afterwards.
    wave_display_idle = 1'b0;
    trig_mode         = 2'b01;
    trig_level        = 16'd1000;
    for (int v = 2000; v >= 1000; v -= 100) strobe(v);
    push_wr(1'b0, 0, 3);  // 900 = 16'h0384
    strobe(900);
    for (int k = 1; k < 256; k++) begin
      push_wr(1'b0, k, k);
      strobe(k << 8);
    end
    repeat (20) @(negedge clk);
    check("wait_flip_read_index", read_index, 1);
    check("wait_flip_capture", capture_active, 0);
    trig_mode  = 2'b00;
    trig_level = 16'd0;
    strobe(-5);  // crossing while waiting must not trigger
    strobe(5);
    check("wait_flip_hold", read_index, 1);
    push_flip(1'b0, 1'b0);
    wave_display_idle = 1'b1;
    repeat (3) @(negedge clk);
    check("flip_after_idle", read_index, 0);

    // Frame 3: decim 3 latched at trigger, changed to 0 mid-capture.
    decim = 4'd3;
    push_flip(1'b1, 1'b1);
    strobe(-10);
    push_wr(1'b1, 0, 0);
    strobe(10);
    decim = 4'd0;
    for (int j = 1; j <= 1020; j++) begin
      if (j % 4 == 0) push_wr(1'b1, j / 4, j / 4);
      strobe(((j >> 2) & 255) << 8);
    end
    repeat (4) @(negedge clk);
    check("decim_read_index", read_index, 1);
    check("decim_all_stored", wq.size(), 0);

    // Frame 4: free-run, aborted by reset at frame index 100.
    trig_mode = 2'b10;
    push_wr(1'b0, 0, 127);
    strobe(16'h7F00);
    for (int j = 1; j < 100; j++) begin
      push_wr(1'b0, j, j);
      strobe(j << 8);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_we", write_enable, 0);
    check("abort_addr", write_address, 0);
    check("abort_sample", write_sample, 0);
    check("abort_read_index", read_index, 0);
    check("abort_capture", capture_active, 0);
    check("abort_frame_done", frame_done, 0);
    repeat (10) @(negedge clk);
    check("abort_no_flip", read_index, 0);
    check("wr_queue_empty", wq.size(), 0);
    check("flip_queue_empty", fq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
